// File: rtl/mycpu_pipe_pkg.sv
// Shared definitions for the mycpu pipeline chain.
package mycpu_pipe_pkg;

    // Largest supported chain depth.
    localparam int unsigned NSTAGE_MAX    = 8;
    // Default width of the retire/stall performance counters.
    localparam int unsigned CNT_W_DEFAULT = 32;

    // Bit offset of stage idx inside a flattened per-stage payload bus.
    function automatic int unsigned stage_lsb(input int unsigned idx, input int unsigned dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/mycpu_pipe_slot.sv
// One pipeline stage: valid/data register, allowin handshake, capture and kill.
module mycpu_pipe_slot
    import mycpu_pipe_pkg::*;
#(
    parameter int unsigned DW = 72
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          up_valid,     // upstream offers a payload this cycle
    input  logic [DW-1:0] up_data,
    input  logic          ready_go,     // this stage finished its work
    input  logic          next_allowin, // downstream can take our payload
    input  logic          kill,         // flush hits this stage
    output logic          allowin,
    output logic          fwd_valid,    // payload leaves this stage this cycle
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    // Handshake: free slot, or our payload moves on in the same cycle.
    always_comb begin
        allowin   = !valid_q || (ready_go && next_allowin);
        fwd_valid = valid_q && ready_go;
    end

    // Stage register; a kill wins over any capture into this slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (kill) begin
                valid_q <= 1'b0;
            end else if (allowin) begin
                valid_q <= up_valid;
            end
            // Bubbles and killed captures leave the payload untouched.
            if (allowin && up_valid && !kill) begin
                data_q <= up_data;
            end
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/mycpu_pipe_chain.sv
// Valid/allowin pipeline chain of NSTAGE slots with flush and performance counters.
module mycpu_pipe_chain
    import mycpu_pipe_pkg::*;
#(
    parameter int unsigned NSTAGE = 4,   // legal range 2..NSTAGE_MAX
    parameter int unsigned DW     = 72,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_allowin,
    input  logic [DW-1:0]        in_data,
    input  logic [NSTAGE-1:0]    ready_go,
    input  logic                 flush,
    input  logic [NSTAGE-1:0]    flush_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [NSTAGE-1:0]    stage_valid,
    output logic [NSTAGE*DW-1:0] stage_data,
    output logic [CNT_W-1:0]     retire_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic [CNT_W-1:0] retire_q;
    logic [CNT_W-1:0] stall_q;

    // Per-stage nets live inside each generate scope so the allowin chain
    // is a set of distinct signals rather than one self-referencing vector.
    for (genvar i = 0; i < NSTAGE; i++) begin : g_slot
        logic          up_valid;
        logic [DW-1:0] up_data;
        logic          nxt_allowin;
        logic          allowin;
        logic          fwd_valid;
        logic          valid;
        logic [DW-1:0] data;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = g_slot[i-1].fwd_valid;
            assign up_data  = g_slot[i-1].data;
        end

        if (i == NSTAGE - 1) begin : g_tail
            assign nxt_allowin = out_ready;
        end else begin : g_link
            assign nxt_allowin = g_slot[i+1].allowin;
        end

        mycpu_pipe_slot #(
            .DW (DW)
        ) u_slot (
            .clk          (clk),
            .resetn       (resetn),
            .up_valid     (up_valid),
            .up_data      (up_data),
            .ready_go     (ready_go[i]),
            .next_allowin (nxt_allowin),
            .kill         (flush && flush_mask[i]),
            .allowin      (allowin),
            .fwd_valid    (fwd_valid),
            .valid        (valid),
            .data         (data)
        );

        assign stage_valid[i]                       = valid;
        assign stage_data[stage_lsb(i, DW) +: DW]   = data;
    end

    assign in_allowin = g_slot[0].allowin;
    assign out_valid  = g_slot[NSTAGE-1].fwd_valid;
    assign out_data   = g_slot[NSTAGE-1].data;

    // Performance counters; both wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retire_q <= '0;
            stall_q  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                retire_q <= retire_q + CNT_W'(1);
            end
            if (in_valid && !in_allowin) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign retire_cnt = retire_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_mycpu_pipe_chain.sv
// Scoreboard bench for mycpu_pipe_chain (NSTAGE=4, DW=8, 4-bit counters to reach wrap quickly).
module tb_mycpu_pipe_chain;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic             in_valid;
    logic             in_allowin;
    logic [DW-1:0]    in_data;
    logic [NS-1:0]    ready_go;
    logic             flush;
    logic [NS-1:0]    flush_mask;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [NS-1:0]    stage_valid;
    logic [NS*DW-1:0] stage_data;
    logic [CW-1:0]    retire_cnt;
    logic [CW-1:0]    stall_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    mycpu_pipe_chain #(
        .NSTAGE (NS),
        .DW     (DW),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_allowin  (in_allowin),
        .in_data     (in_data),
        .ready_go    (ready_go),
        .flush       (flush),
        .flush_mask  (flush_mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .retire_cnt  (retire_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit expect_out);
        in_valid = 1'b1;
        in_data  = d;
        if (expect_out) exp_q.push_back(d);
        step();
    endtask

    // Step until the chain is empty; an expired budget counts as a failure.
    task automatic drain();
        int n = 0;
        while (stage_valid != '0 && n < 20) begin
            step();
            n++;
        end
        check("drain_budget", 32'(n < 20), 32'd1);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (resetn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got 0x%0h expected no output", out_data);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    endtask

    task automatic stimulus();
        resetn     = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        ready_go   = '1;
        flush      = 1'b0;
        flush_mask = '0;
        out_ready  = 1'b1;
        #2 resetn = 1'b0;
        #2;
        check("rst_stage_valid", 32'(stage_valid), 32'h0);
        check("rst_stage_data",  32'(stage_data),  32'h0);
        check("rst_in_allowin",  32'(in_allowin),  32'h1);
        check("rst_out_valid",   32'(out_valid),   32'h0);
        check("rst_retire",      32'(retire_cnt),  32'h0);
        check("rst_stall",       32'(stall_cnt),   32'h0);
        // No capture while held in reset, even across an edge.
        in_valid = 1'b1;
        in_data  = 8'hEE;
        step();
        check("rst_no_capture", 32'(stage_valid), 32'h0);
        in_valid = 1'b0;
        step();
        #1 resetn = 1'b1;

        // Streaming: latency 4 edges, one per cycle.
        send(8'h11, 1'b1);
        check("lat_e0", 32'(stage_valid), 32'h1);
        send(8'h22, 1'b1);
        check("lat_e1", 32'(stage_valid), 32'h3);
        send(8'h33, 1'b1);
        check("lat_e2", 32'(stage_valid), 32'h7);
        check("lat_e2_out", 32'(out_valid), 32'h0);
        in_valid = 1'b0;
        step();
        check("lat_e3", 32'(stage_valid), 32'hE);
        check("lat_e3_out", 32'(out_valid), 32'h1);
        drain();
        check("stream_retire", 32'(retire_cnt), 32'd3);

        // Stall at stage 1 for three cycles.
        send(8'h41, 1'b1);
        send(8'h42, 1'b1);
        ready_go = 4'b1101;
        in_data  = 8'h43;
        exp_q.push_back(8'h43);
        #1;
        check("stall_allowin", 32'(in_allowin), 32'h0);
        step();
        step();
        step();
        check("stall_valid", 32'(stage_valid), 32'h3);
        check("stall_hold_s0", 32'(stage_data[7:0]), 32'h42);
        check("stall_hold_s1", 32'(stage_data[15:8]), 32'h41);
        ready_go = '1;
        step();
        in_valid = 1'b0;
        drain();
        check("stall_cnt", 32'(stall_cnt), 32'd3);
        check("stall_retire", 32'(retire_cnt), 32'd6);

        // Backpressure: fill all four stages with the consumer blocked.
        out_ready = 1'b0;
        send(8'h61, 1'b1);
        send(8'h62, 1'b1);
        send(8'h63, 1'b1);
        send(8'h64, 1'b1);
        in_valid = 1'b0;
        #1;
        check("bp_full", 32'(stage_valid), 32'hF);
        check("bp_allowin", 32'(in_allowin), 32'h0);
        check("bp_out_valid", 32'(out_valid), 32'h1);
        step();
        step();
        check("bp_out_hold", 32'(out_data), 32'h61);
        check("bp_still_full", 32'(stage_valid), 32'hF);
        out_ready = 1'b1;
        drain();
        check("bp_retire", 32'(retire_cnt), 32'd10);

        // Flush stages 0 and 1 while the chain streams full.
        send(8'h71, 1'b1);
        send(8'h72, 1'b1);
        send(8'h73, 1'b1);
        send(8'h74, 1'b0);
        flush      = 1'b1;
        flush_mask = 4'b0011;
        send(8'h75, 1'b0);
        flush      = 1'b0;
        flush_mask = 4'b1111;
        in_valid   = 1'b0;
        check("flush_valid", 32'(stage_valid), 32'hC);
        check("flush_s2", 32'(stage_data[23:16]), 32'h73);
        check("flush_s3", 32'(stage_data[31:24]), 32'h72);
        drain();
        check("flush_retire", 32'(retire_cnt), 32'd13);

        // Three more retirements take the 4-bit counter through 15 to 0.
        send(8'h81, 1'b1);
        send(8'h82, 1'b1);
        send(8'h83, 1'b1);
        in_valid = 1'b0;
        drain();
        check("wrap_retire", 32'(retire_cnt), 32'd0);

        // Reset in mid-stream discards in-flight payloads immediately.
        send(8'h91, 1'b0);
        send(8'h92, 1'b0);
        send(8'h93, 1'b0);
        in_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(stage_valid), 32'h0);
        check("mid_rst_retire", 32'(retire_cnt), 32'h0);
        check("mid_rst_stall", 32'(stall_cnt), 32'h0);
        check("mid_rst_allowin", 32'(in_allowin), 32'h1);
        check("mid_rst_out_valid", 32'(out_valid), 32'h0);
        step();
        #1 resetn = 1'b1;
        send(8'h5A, 1'b1);
        in_valid = 1'b0;
        drain();
        check("post_rst_retire", 32'(retire_cnt), 32'd1);
        step();
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            begin
                #100000;
                n_cmp++;
                n_err++;
                $display("FAIL timeout: got no completion expected completion");
            end
        join_any
        disable fork;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
